// File: rtl/mux_pipe_n_if.sv
// Bundle of the producer-side and consumer-side signals of the registered N:1 mux.
// The mux itself connects through the slave modport; whoever drives it uses master.
interface mux_pipe_n_if #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);

  logic [WIDTH*NUM_IN-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_sel;
  logic                    sel_err;

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_sel,
    input  sel_err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output out_sel,
    output sel_err
  );

endinterface

// File: rtl/mux_pipe_n.sv
// Registered NUM_IN:1 multiplexer with valid/ready handshake, one output stage,
// explicit-select or round-robin channel choice.
module mux_pipe_n #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic       clk,
  input  logic       reset,
  mux_pipe_n_if.slave bus
);

  localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_next;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_sel_q;
  logic              sel_err_q;

  logic              load_en;
  logic              sel_oor;
  logic [NUM_IN-1:0] valid_rot;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_off;
  logic [SEL_W:0]    rr_sum;
  logic              hit;
  logic [SEL_W-1:0]  gidx;
  logic [NUM_IN-1:0] ready_vec;
  logic              accept;
  logic [WIDTH-1:0]  mux_data;

  assign load_en   = !out_valid_q || bus.out_ready;
  assign sel_oor   = {1'b0, bus.sel} >= NUM_IN_W;

  // Rotate valids so bit 0 is the channel at rr_ptr; the first set bit is the winner.
  assign valid_rot = NUM_IN'({bus.in_valid, bus.in_valid} >> rr_ptr);

  always_comb begin
    rr_hit = 1'b0;
    rr_off = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!rr_hit && valid_rot[k]) begin
        rr_hit = 1'b1;
        rr_off = SEL_W'(k);
      end
    end
    rr_sum = {1'b0, rr_ptr} + {1'b0, rr_off};
    if (rr_sum >= NUM_IN_W) begin
      rr_sum = rr_sum - NUM_IN_W;
    end
  end

  // Explicit mode targets sel whenever it is in range, even if that channel is idle.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    if (!bus.mode) begin
      hit  = !sel_oor;
      gidx = bus.sel;
    end else begin
      hit  = rr_hit;
      gidx = rr_sum[SEL_W-1:0];
    end
  end

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      ready_vec[i] = !reset && load_en && hit && (gidx == SEL_W'(i));
    end
  end

  assign accept = |(ready_vec & bus.in_valid);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gidx == SEL_W'(i)) begin
        mux_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  // Output stage: load on accept, drain when free and nothing arrives, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      sel_err_q <= !bus.mode && sel_oor;
      if (load_en) begin
        if (accept) begin
          out_valid_q <= 1'b1;
          out_data_q  <= mux_data;
          out_sel_q   <= gidx;
          if (bus.mode) begin
            rr_ptr <= rr_next;
          end
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.sel_err   = sel_err_q;

endmodule
